// File: rtl/merge_pipe_if.sv
// Flit bus into and out of merge_pipe: stall, per-port flit fields in, merged results out.
// The producer side uses the master modport and merge_pipe uses the slave modport.
interface merge_pipe_if #(
    parameter int NUM_PORT   = 5,
    parameter int SRC_LIST_W = 16,
    parameter int ADDR_W     = 32,
    parameter int DST_W      = 16,
    parameter int FLITID_W   = 3
);
    logic                           stall;
    logic [NUM_PORT-1:0]            in_hs;
    logic [NUM_PORT*SRC_LIST_W-1:0] in_src_list;
    logic [NUM_PORT*ADDR_W-1:0]     in_addr;
    logic [NUM_PORT*DST_W-1:0]      in_dst;
    logic [NUM_PORT*FLITID_W-1:0]   in_flit_id;
    logic [NUM_PORT-1:0]            out_hs;
    logic [NUM_PORT-1:0]            out_kill;
    logic [NUM_PORT*SRC_LIST_W-1:0] out_src_list;

    modport master (
        output stall, in_hs, in_src_list, in_addr, in_dst, in_flit_id,
        input  out_hs, out_kill, out_src_list
    );

    modport slave (
        input  stall, in_hs, in_src_list, in_addr, in_dst, in_flit_id,
        output out_hs, out_kill, out_src_list
    );
endinterface

// File: rtl/merge_pipe.sv
// Registered multicast merge stage: identical flits collapse onto the lowest-index member, which
// carries the OR of the group's source lists. Define MERGE_STATS_EN for the saturating merge counter.
module merge_pipe #(
    parameter int NUM_PORT   = 5,
    parameter int SRC_LIST_W = 16,
    parameter int ADDR_W     = 32,
    parameter int DST_W      = 16,
    parameter int FLITID_W   = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MERGE_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] merge_cnt,
`endif
    merge_pipe_if.slave      bus
);
    localparam int KEY_W = ADDR_W + DST_W + FLITID_W;
    localparam int POP_W = $clog2(NUM_PORT + 1);

    logic [NUM_PORT*KEY_W-1:0]      keys_s;
    logic [NUM_PORT-1:0]            kill_s;
    logic [SRC_LIST_W-1:0]          acc_s;
    logic [NUM_PORT*SRC_LIST_W-1:0] src_new_s;

    logic [NUM_PORT-1:0]            out_hs_d,   out_hs_q;
    logic [NUM_PORT-1:0]            out_kill_d, out_kill_q;
    logic [NUM_PORT*SRC_LIST_W-1:0] out_src_d,  out_src_q;

    function automatic logic pair_match(input logic [NUM_PORT-1:0] hs,
                                        input logic [NUM_PORT*KEY_W-1:0] keys,
                                        input int i, input int j);
        return hs[i] & hs[j] & (keys[i*KEY_W +: KEY_W] == keys[j*KEY_W +: KEY_W]);
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [NUM_PORT-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            c = c + POP_W'(v[k]);
        end
        return c;
    endfunction

    // Compare keys, derive kills, fold each group's source lists into its lowest-index survivor.
    always_comb begin
        keys_s    = '0;
        kill_s    = '0;
        acc_s     = '0;
        src_new_s = bus.in_src_list;
        for (int p = 0; p < NUM_PORT; p++) begin
            keys_s[p*KEY_W +: KEY_W] = {bus.in_addr[p*ADDR_W +: ADDR_W],
                                        bus.in_dst[p*DST_W +: DST_W],
                                        bus.in_flit_id[p*FLITID_W +: FLITID_W]};
        end
        for (int j = 1; j < NUM_PORT; j++) begin
            for (int i = 0; i < j; i++) begin
                kill_s[j] = kill_s[j] | pair_match(bus.in_hs, keys_s, i, j);
            end
        end
        for (int i = 0; i < NUM_PORT; i++) begin
            acc_s = bus.in_src_list[i*SRC_LIST_W +: SRC_LIST_W];
            for (int j = i + 1; j < NUM_PORT; j++) begin
                acc_s = acc_s | (pair_match(bus.in_hs, keys_s, i, j) ?
                                 bus.in_src_list[j*SRC_LIST_W +: SRC_LIST_W] :
                                 {SRC_LIST_W{1'b0}});
            end
            src_new_s[i*SRC_LIST_W +: SRC_LIST_W] = (bus.in_hs[i] & ~kill_s[i]) ? acc_s :
                                bus.in_src_list[i*SRC_LIST_W +: SRC_LIST_W];
        end
    end

    // Output next state: capture fresh results unless stalled.
    always_comb begin
        out_hs_d   = out_hs_q;
        out_kill_d = out_kill_q;
        out_src_d  = out_src_q;
        if (!bus.stall) begin
            out_hs_d   = bus.in_hs & ~kill_s;
            out_kill_d = kill_s;
            out_src_d  = src_new_s;
        end else begin
            out_hs_d   = out_hs_q;
            out_kill_d = out_kill_q;
            out_src_d  = out_src_q;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_hs_q   <= '0;
            out_kill_q <= '0;
            out_src_q  <= '0;
        end else begin
            out_hs_q   <= out_hs_d;
            out_kill_q <= out_kill_d;
            out_src_q  <= out_src_d;
        end
    end

    assign bus.out_hs       = out_hs_q;
    assign bus.out_kill     = out_kill_q;
    assign bus.out_src_list = out_src_q;

`ifdef MERGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W:0]   cnt_sum_s;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Counter next state: clear beats stall and increment; the sum carries one spare bit to saturate.
    always_comb begin
        cnt_sum_s = {1'b0, cnt_q} + (CNT_W+1)'(popcount(kill_s));
        if (stats_clr) begin
            cnt_d = '0;
        end else if (bus.stall) begin
            cnt_d = cnt_q;
        end else if (cnt_sum_s > {1'b0, CNT_MAX}) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Merge counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign merge_cnt = cnt_q;
`endif
endmodule
